// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and FSM state type for the mac_accum frame accumulator.
package mac_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;

  localparam logic [PROD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [PROD_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_sat.sv
// Combinational 40->32 narrowing of the frame sum with signed-range overflow detect.
// Build option MAC_ACCUM_SAT_EN: clamp to SAT_MAX/SAT_MIN on overflow instead of truncating.
module mac_sat
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_i,
  output logic [PROD_W-1:0] data_o,
  output logic              ovf_o
);

  // The sum fits in 32 signed bits only when bits 39..31 are all copies of the sign.
  always_comb begin
    ovf_o = (acc_i[ACC_W-1:PROD_W-1] != {(ACC_W-PROD_W+1){acc_i[ACC_W-1]}});
`ifdef MAC_ACCUM_SAT_EN
    if (ovf_o) begin
      data_o = acc_i[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      data_o = acc_i[PROD_W-1:0];
    end
`else
    data_o = acc_i[PROD_W-1:0];
`endif
  end

endmodule

// File: rtl/mac_accum.sv
// Frame accumulator: sums FRAME_LEN signed 32-bit products, presents one 32-bit sum per frame.
// Build option MAC_ACCUM_SAT_EN selects saturating rather than truncating output (see mac_sat).
module mac_accum #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf
);
  import mac_pkg::*;

  localparam int CNT_W = 9;

  if (FRAME_LEN < 1 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("mac_accum: FRAME_LEN must lie within 1..256");
  end
  if (ACC_W != mac_pkg::ACC_W) begin : g_bad_acc_w
    $error("mac_accum: ACC_W is fixed at 40");
  end

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROD_W-1:0]  out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   ext_s, base_s, sum_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [PROD_W-1:0]  sat_data_s;
  logic               sat_ovf_s;
  logic               in_beat_s, out_beat_s;

  // Running sum including the beat on this edge; IDLE starts a fresh frame.
  always_comb begin
    ext_s     = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
    base_s    = (state_q == IDLE) ? '0 : acc_q;
    sum_s     = base_s + ext_s;
    cnt_inc_s = cnt_q + 9'd1;
    in_beat_s  = in_valid & in_ready_q;
    out_beat_s = out_valid_q & out_ready;
  end

  mac_sat u_sat (
    .acc_i  (sum_s),
    .data_o (sat_data_s),
    .ovf_o  (sat_ovf_s)
  );

  // Next-state logic; the final beat's sum is captured into the output registers on HOLD entry.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_beat_s) begin
          acc_d = sum_s;
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_W'(FRAME_LEN)) begin
            state_d    = HOLD;
            out_data_d = sat_data_s;
            out_ovf_d  = sat_ovf_s;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_beat_s) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 SHALL provide parameter FRAME_LEN, default 16: number of accepted products summed per output frame; legal range 1..256.
REQ-002 SHALL provide parameter ACC_W, default 40: internal accumulator width, fixed at 32+8.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1: synchronous frame abort.
REQ-006 SHALL have port in_valid, input, 1: upstream product valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept a product.
REQ-008 SHALL have port in_data, input, 32: signed product from the registered 16x16 multiply stage.
REQ-009 SHALL have port out_valid, output, 1: frame sum available.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the sum.
REQ-011 SHALL have port out_data, output, 32: signed frame sum.
REQ-012 SHALL have port out_ovf, output, 1: sum exceeded the signed 32-bit range.

Function
REQ-013 SHALL define an input beat as in_valid=1 and in_ready=1 on the same rising edge; an output beat as out_valid=1 and out_ready=1.
REQ-014 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-015 IDLE: in_ready=1; on a beat, acc <= sign-extended in_data, cnt <= 1, next state ACCUM, or HOLD when FRAME_LEN=1.
REQ-016 ACCUM: in_ready=1; on a beat, acc <= acc + sign-extended in_data, cnt <= cnt+1; when cnt+1 = FRAME_LEN, next state HOLD; no beat means acc and cnt hold.
REQ-017 HOLD: in_ready=0, out_valid=1; out_data and out_ovf SHALL stay stable until the output beat, which returns the FSM to IDLE with cnt=0.
REQ-018 SHALL assert out_valid exactly one cycle after the FRAME_LEN-th input beat; throughput SHALL be one bubble cycle per frame minimum.
REQ-019 SHALL register out_data and out_ovf on HOLD entry from the ACC_W-bit sum that includes the final beat.
REQ-020 SHALL never wrap the accumulator, since 256 x 2^31 fits in 40 signed bits.
REQ-021 SHALL set out_ovf=1 when the 40-bit sum is outside -2^31..2^31-1; otherwise out_ovf=0.
REQ-022 clr=1 SHALL have highest priority: next state IDLE, acc=0, cnt=0, out_valid=0; an input or output beat coincident with clr SHALL be discarded.
REQ-023 SHALL ignore in_valid while in HOLD, with no change to acc or cnt.

Reset
REQ-024 rst=0 SHALL immediately force state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_ovf=0, independent of clk.
REQ-025 in_ready SHALL read 1 from the first cycle after reset release.
REQ-026 Reset mid-frame SHALL discard the partial sum; no out_valid pulse SHALL follow it.

Configuration
REQ-027 Macro MAC_ACCUM_SAT_EN defined: out_data SHALL saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) when out_ovf=1.
REQ-028 Macro MAC_ACCUM_SAT_EN undefined: out_data SHALL be acc[31:0] (truncation); out_ovf behaves identically.

Structure
REQ-029 Package mac_pkg SHALL hold: PROD_W=32, ACC_W=40, SAT_MAX and SAT_MIN constants, and the FSM state enum typedef.
REQ-030 Sub-module mac_sat SHALL be combinational 40->32 conversion plus ovf detect, with the saturating path selected by MAC_ACCUM_SAT_EN.
REQ-031 SHALL reject FRAME_LEN outside 1..256 at elaboration.

Verification
REQ-032 FRAME_LEN=4, beats 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=10, out_ovf=0, in_ready low exactly one cycle.
REQ-033 FRAME_LEN=2, beats 0x7FFFFFFF,0x00000001 -> out_ovf=1; out_data=0x7FFFFFFF with SAT_EN, 0x80000000 without.
REQ-034 FRAME_LEN=2, beats -5,-7, out_ready held 0 for 5 cycles -> out_data=-12 stable, in_ready=0 throughout, IDLE after accept.
REQ-035 FRAME_LEN=4, 2 beats then clr=1 with in_valid=1, then beats 1,1,1,1 -> out_data=4, the clr-cycle beat not counted.
REQ-036 rst pulsed low mid-frame between clk edges -> outputs zero immediately, no out_valid, next frame sums from zero.
REQ-037 FRAME_LEN=1, in_valid with random gaps -> each beat yields one frame equal to in_data; scoreboard matches 1000 beats.
